adder_issue_buffer: RTL and testbench



---
 rtl/crackcore_pkg.sv | 63 ++++++
 rtl/issue_fifo.sv | 55 +++++
 rtl/adder_issue_buffer.sv | 112 +++++++++++
 tb/tb_adder_issue_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crackcore_pkg.sv
// Shared CrackCore backend definitions for the adder issue path.
// Carries the physical-register width, the adder micro-op word layout and the
// field offsets used by dispatch, the adder issue buffer and the adder unit.
// Info word layout, MSB first:
//   {lui, auipc, addi, addiw, add, addw, sub, subw, pc[63:0], imm[63:0], rd0, rs1, rs2}
package crackcore_pkg;

    localparam int unsigned DEFAULT_RNBIT = 2;
    localparam int unsigned ADDER_OP_W    = 8;

    // Bit positions inside the op field (subw is the LSB of the op field).
    localparam int unsigned OP_SUBW  = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_ADDW  = 2;
    localparam int unsigned OP_ADD   = 3;
    localparam int unsigned OP_ADDIW = 4;
    localparam int unsigned OP_ADDI  = 5;
    localparam int unsigned OP_AUIPC = 6;
    localparam int unsigned OP_LUI   = 7;

    // Helpers so units built with a non-default rename width share the layout.
    function automatic int unsigned preg_width(input int unsigned rnbit);
        return 5 + rnbit;
    endfunction

    function automatic int unsigned adder_info_width(input int unsigned pw);
        return ADDER_OP_W + 128 + 3 * pw;
    endfunction

    function automatic int unsigned rs2_lsb(input int unsigned pw);
        return 0 * pw;
    endfunction

    function automatic int unsigned rs1_lsb(input int unsigned pw);
        return pw;
    endfunction

    function automatic int unsigned rd0_lsb(input int unsigned pw);
        return 2 * pw;
    endfunction

    function automatic int unsigned imm_lsb(input int unsigned pw);
        return 3 * pw;
    endfunction

    function automatic int unsigned pc_lsb(input int unsigned pw);
        return 3 * pw + 64;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned pw);
        return 3 * pw + 128;
    endfunction

    localparam int unsigned PREG_W       = preg_width(DEFAULT_RNBIT);
    localparam int unsigned ADDER_INFO_W = adder_info_width(PREG_W);
    localparam int unsigned RS2_LSB      = rs2_lsb(PREG_W);
    localparam int unsigned RS1_LSB      = rs1_lsb(PREG_W);
    localparam int unsigned RD0_LSB      = rd0_lsb(PREG_W);
    localparam int unsigned IMM_LSB      = imm_lsb(PREG_W);
    localparam int unsigned PC_LSB       = pc_lsb(PREG_W);
    localparam int unsigned OP_LSB       = op_lsb(PREG_W);

endpackage

// File: rtl/issue_fifo.sv
// In-order issue FIFO with flush.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO at the next edge (priority over push/pop)
//   push/wdata : write one entry; caller must not push when full
//   pop/rdata  : rdata is the head entry; pop advances the read pointer
//   count      : number of stored entries
//   full/empty : occupancy flags
module issue_fifo #(
    parameter int unsigned DP = 4,
    parameter int unsigned DW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DW-1:0]          wdata,
    input  logic                   pop,
    output logic [DW-1:0]          rdata,
    output logic [$clog2(DP):0]    count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DP);

    // One extra pointer bit distinguishes full from empty after wrap-around.
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [DW-1:0] mem_q [DP];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/adder_issue_buffer.sv
// Adder-class issue buffer (lui, auipc, addi, addiw, add, addw, sub, subw).
// Accepts micro-ops from dispatch, holds them in program order and issues the
// head to the adder once its needed source registers have been written back.
// Ports:
//   CLK, RSTn                 : clock, asynchronous active-low reset
//   adder_issue_vaild/ready   : dispatch handshake
//   adder_issue_info          : micro-op word (layout in crackcore_pkg)
//   wbLog                     : written-back flag per physical register
//   flush                     : discards buffered and presented micro-ops
//   adder_execute_vaild/ready : handshake towards the adder
//   adder_execute_info        : registered copy of the issued micro-op
module adder_issue_buffer
    import crackcore_pkg::*;
#(
    parameter int unsigned DP    = 4,
    parameter int unsigned RNBIT = DEFAULT_RNBIT
) (
    input  logic                                   CLK,
    input  logic                                   RSTn,
    input  logic                                   adder_issue_vaild,
    output logic                                   adder_issue_ready,
    input  logic [ADDER_OP_W+128+3*(5+RNBIT)-1:0]  adder_issue_info,
    input  logic [32*(2**RNBIT)-1:0]               wbLog,
    input  logic                                   flush,
    output logic                                   adder_execute_vaild,
    input  logic                                   adder_execute_ready,
    output logic [ADDER_OP_W+128+3*(5+RNBIT)-1:0]  adder_execute_info
);

    localparam int unsigned PW   = preg_width(RNBIT);
    localparam int unsigned IW   = adder_info_width(PW);
    localparam int unsigned OPL  = op_lsb(PW);
    localparam int unsigned RS1L = rs1_lsb(PW);
    localparam int unsigned RS2L = rs2_lsb(PW);
    localparam int unsigned AW   = $clog2(DP);
    localparam logic [AW:0] DP_CNT = DP[AW:0];

    logic [IW-1:0] head;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          fire;
    logic [PW-1:0] rs1_idx;
    logic [PW-1:0] rs2_idx;
    logic          need_rs1;
    logic          need_rs2;
    logic          rs1_ok;
    logic          rs2_ok;
    logic          out_free;

    logic          exec_valid_q;
    logic [IW-1:0] exec_info_q;

    // Ready is taken from registered occupancy, so a pop in the same cycle
    // never frees a slot for a push while full.
    assign adder_issue_ready = (fifo_count < DP_CNT) & ~flush;
    assign push              = adder_issue_vaild & adder_issue_ready;

    issue_fifo #(
        .DP (DP),
        .DW (IW)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTn),
        .flush (flush),
        .push  (push),
        .wdata (adder_issue_info),
        .pop   (fire),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Source readiness of the head entry. Arch register 0 is hard-wired zero,
    // so it never waits regardless of its rename bits.
    assign rs1_idx  = head[RS1L +: PW];
    assign rs2_idx  = head[RS2L +: PW];
    assign need_rs1 = head[OPL + OP_ADDI] | head[OPL + OP_ADDIW] | head[OPL + OP_ADD]
                    | head[OPL + OP_ADDW] | head[OPL + OP_SUB]   | head[OPL + OP_SUBW];
    assign need_rs2 = head[OPL + OP_ADD]  | head[OPL + OP_ADDW]  | head[OPL + OP_SUB]
                    | head[OPL + OP_SUBW];
    assign rs1_ok   = ~need_rs1 | (rs1_idx[PW-1:RNBIT] == '0) | wbLog[rs1_idx];
    assign rs2_ok   = ~need_rs2 | (rs2_idx[PW-1:RNBIT] == '0) | wbLog[rs2_idx];

    assign out_free = ~exec_valid_q | adder_execute_ready;
    assign fire     = ~fifo_empty & rs1_ok & rs2_ok & out_free & ~flush;

    // Output register: info only changes on fire so it is stable while stalled.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            exec_valid_q <= 1'b0;
            exec_info_q  <= '0;
        end else if (flush) begin
            exec_valid_q <= 1'b0;
        end else if (fire) begin
            exec_valid_q <= 1'b1;
            exec_info_q  <= head;
        end else if (adder_execute_ready) begin
            exec_valid_q <= 1'b0;
        end
    end

    assign adder_execute_vaild = exec_valid_q;
    assign adder_execute_info  = exec_info_q;

    // Occupancy flags come from the same pointers and must agree.
    full_consistent_a: assert property (@(posedge CLK) disable iff (!RSTn)
        fifo_full == (fifo_count == DP_CNT));

endmodule

// File: tb/tb_adder_issue_buffer.sv
module tb_adder_issue_buffer;

    localparam int IW = 157;

    localparam logic [7:0] LUI   = 8'h80;
    localparam logic [7:0] AUIPC = 8'h40;
    localparam logic [7:0] ADDI  = 8'h20;
    localparam logic [7:0] ADDIW = 8'h10;
    localparam logic [7:0] ADD   = 8'h08;
    localparam logic [7:0] ADDW  = 8'h04;
    localparam logic [7:0] SUB   = 8'h02;
    localparam logic [7:0] SUBW  = 8'h01;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iv;
    logic          ir;
    logic [IW-1:0] ii;
    logic [127:0]  wb;
    logic          fl;
    logic          ev;
    logic          er;
    logic [IW-1:0] ei;

    int checks   = 0;
    int failures = 0;

    // Reference model: program-order queue plus the presented micro-op.
    logic [IW-1:0] mq[$];
    logic          m_v;
    logic [IW-1:0] m_info;

    always #5 clk = ~clk;

    adder_issue_buffer #(
        .DP    (4),
        .RNBIT (2)
    ) dut (
        .CLK                 (clk),
        .RSTn                (rst_n),
        .adder_issue_vaild   (iv),
        .adder_issue_ready   (ir),
        .adder_issue_info    (ii),
        .wbLog               (wb),
        .flush               (fl),
        .adder_execute_vaild (ev),
        .adder_execute_ready (er),
        .adder_execute_info  (ei)
    );

    function automatic logic [IW-1:0] mk(input logic [7:0] op, input logic [63:0] pc,
                                         input logic [63:0] imm, input logic [6:0] rd,
                                         input logic [6:0] rs1, input logic [6:0] rs2);
        return {op, pc, imm, rd, rs1, rs2};
    endfunction

    function automatic logic [63:0] pc_of(input logic [IW-1:0] w);
        return w[148:85];
    endfunction

    // A source is usable if the op ignores it, it names x0, or it was written back.
    function automatic bit src_ready(input logic [IW-1:0] e, input bit second);
        logic [7:0] op;
        logic [6:0] r;
        bit         need;
        op   = e[156:149];
        r    = second ? e[6:0] : e[13:7];
        need = second ? (op & (ADD | ADDW | SUB | SUBW)) != 0
                      : (op & (ADDI | ADDIW | ADD | ADDW | SUB | SUBW)) != 0;
        return !need || (r[6:2] == 5'd0) || wb[r];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_v    = 1'b0;
        m_info = '0;
    endtask

    task automatic model_step();
        bit can_take;
        if (!rst_n) begin
            model_reset();
        end else if (fl) begin
            mq.delete();
            m_v = 1'b0;
        end else begin
            can_take = mq.size() < 4;
            if (mq.size() > 0 && src_ready(mq[0], 0) && src_ready(mq[0], 1) && (!m_v || er)) begin
                m_info = mq.pop_front();
                m_v    = 1'b1;
            end else if (er) begin
                m_v = 1'b0;
            end
            if (iv && can_take) mq.push_back(ii);
        end
    endtask

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("model_issue_ready", IW'(ir), IW'(mq.size() < 4 && !fl));
        chk("model_exec_valid", IW'(ev), IW'(m_v));
        chk("model_exec_info", ei, m_info);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic clear_all();
        iv = 1'b0;
        fl = 1'b1;
        cycle();
        fl = 1'b0;
    endtask

    typedef struct {
        logic [7:0] op;
        logic [6:0] rs1;
        logic [6:0] rs2;
        bit         wb_all;
        bit         exp_issue;
    } vec_t;

    vec_t          tv[10];
    logic [IW-1:0] w;
    logic [IW-1:0] w0;
    logic [63:0]   got_pc[$];

    initial begin
        tv[0] = '{LUI,   7'h14, 7'h15, 1'b0, 1'b1};
        tv[1] = '{AUIPC, 7'h14, 7'h15, 1'b0, 1'b1};
        tv[2] = '{ADDI,  7'h14, 7'h00, 1'b0, 1'b0};
        tv[3] = '{ADDI,  7'h03, 7'h15, 1'b0, 1'b1};
        tv[4] = '{ADD,   7'h00, 7'h1C, 1'b0, 1'b0};
        tv[5] = '{ADD,   7'h02, 7'h01, 1'b0, 1'b1};
        tv[6] = '{SUB,   7'h14, 7'h1C, 1'b1, 1'b1};
        tv[7] = '{ADDIW, 7'h00, 7'h7F, 1'b0, 1'b1};
        tv[8] = '{SUBW,  7'h7F, 7'h00, 1'b0, 1'b0};
        tv[9] = '{ADDW,  7'h04, 7'h08, 1'b0, 1'b0};

        rst_n = 1'b0;
        iv    = 1'b0;
        ii    = '0;
        wb    = '0;
        fl    = 1'b0;
        er    = 1'b0;
        model_reset();
        cycle();
        cycle();
        chk("reset_issue_ready", IW'(ir), IW'(1));
        chk("reset_exec_valid", IW'(ev), IW'(0));
        chk("reset_exec_info", ei, '0);
        rst_n = 1'b1;
        cycle();

        // Reset in the middle of a burst of three blocked pushes.
        for (int i = 0; i < 3; i++) begin
            iv = 1'b1;
            ii = mk(ADDI, 64'h40 + 64'(4 * i), 64'd1, 7'h0A, 7'h14, 7'h00);
            cycle();
        end
        iv    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_issue_ready", IW'(ir), IW'(1));
        chk("midreset_exec_valid", IW'(ev), IW'(0));
        model_reset();
        cycle();
        rst_n = 1'b1;
        wb    = '1;
        er    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("postreset_no_issue", IW'(ev), IW'(0));
        end

        // addi waits on rs1 until its written-back flag rises.
        wb = '0;
        er = 1'b0;
        w  = mk(ADDI, 64'h200, 64'd5, 7'h0A, 7'h14, 7'h00);
        iv = 1'b1;
        ii = w;
        cycle();
        iv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("wait_rs1_blocked", IW'(ev), IW'(0));
        end
        wb[7'h14] = 1'b1;
        cycle();
        chk("wait_rs1_issued", IW'(ev), IW'(1));
        chk("wait_rs1_info", ei, w);
        er = 1'b1;
        cycle();
        chk("drain_clears_valid", IW'(ev), IW'(0));

        // Single-entry operand-readiness vectors, each from an empty buffer.
        for (int i = 0; i < 10; i++) begin
            wb = tv[i].wb_all ? '1 : '0;
            er = 1'b1;
            w  = mk(tv[i].op, 64'h300 + 64'(4 * i), 64'h12345000, 7'h0B, tv[i].rs1, tv[i].rs2);
            iv = 1'b1;
            ii = w;
            cycle();
            iv = 1'b0;
            chk("vec_not_yet", IW'(ev), IW'(0));
            cycle();
            chk("vec_issue", IW'(ev), IW'(tv[i].exp_issue));
            if (tv[i].exp_issue) chk("vec_info", ei, w);
            clear_all();
            chk("vec_flushed", IW'(ev), IW'(0));
        end

        // Fill with blocked entries, then release them under back-pressure.
        wb = '0;
        er = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv = 1'b1;
            ii = mk(ADD, 64'h100 + 64'(4 * i), 64'd0, 7'h01, 7'h14, 7'h18);
            cycle();
        end
        chk("fill_ready_low", IW'(ir), IW'(0));
        ii = mk(ADD, 64'h110, 64'd0, 7'h01, 7'h14, 7'h18);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("fill_hold_ready", IW'(ir), IW'(0));
            chk("fill_hold_valid", IW'(ev), IW'(0));
        end
        iv = 1'b0;
        wb = '1;
        cycle();
        chk("stall_valid", IW'(ev), IW'(1));
        w0 = ei;
        chk("stall_first_pc", IW'(pc_of(ei)), IW'(64'h100));
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_info_stable", ei, w0);
            chk("stall_valid_held", IW'(ev), IW'(1));
        end
        er = 1'b1;
        got_pc.delete();
        for (int i = 0; i < 20 && got_pc.size() < 4; i++) begin
            if (ev) got_pc.push_back(pc_of(ei));
            cycle();
        end
        chk("drain_count", IW'(got_pc.size()), IW'(4));
        for (int i = 0; i < got_pc.size(); i++)
            chk("drain_order", IW'(got_pc[i]), IW'(64'h100 + 64'(4 * i)));

        // Back-to-back stream: one issue per cycle across pointer wrap.
        clear_all();
        er = 1'b1;
        wb = '0;
        for (int k = 1; k <= 22; k++) begin
            iv = (k <= 20);
            ii = mk(LUI, 64'h1000 + 64'(4 * (k - 1)), 64'h12345000, 7'h02, 7'h00, 7'h00);
            cycle();
            chk("stream_ready", IW'(ir), IW'(1));
            if (k >= 2 && k <= 21) begin
                chk("stream_valid", IW'(ev), IW'(1));
                chk("stream_pc", IW'(pc_of(ei)), IW'(64'h1000 + 64'(4 * (k - 2))));
            end
        end
        iv = 1'b0;
        cycle();
        chk("stream_end_valid", IW'(ev), IW'(0));

        // Flush with output valid, three buffered and a push on offer.
        clear_all();
        er = 1'b0;
        wb = '0;
        iv = 1'b1;
        ii = mk(LUI, 64'h500, 64'd7, 7'h03, 7'h00, 7'h00);
        cycle();
        for (int i = 0; i < 3; i++) begin
            ii = mk(SUB, 64'h504 + 64'(4 * i), 64'd0, 7'h03, 7'h14, 7'h18);
            cycle();
        end
        chk("preflush_valid", IW'(ev), IW'(1));
        fl = 1'b1;
        ii = mk(LUI, 64'hDEAD, 64'd9, 7'h04, 7'h00, 7'h00);
        #1;
        chk("flush_ready_low", IW'(ir), IW'(0));
        cycle();
        fl = 1'b0;
        iv = 1'b0;
        chk("flush_valid_cleared", IW'(ev), IW'(0));
        wb = '1;
        er = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("flush_nothing_left", IW'(ev), IW'(0));
        end

        // Randomized traffic against the model.
        wb = '0;
        for (int c = 0; c < 500; c++) begin
            logic [6:0] r1;
            logic [6:0] r2;
            r1 = ($urandom_range(0, 3) == 0) ? {5'd0, 2'($urandom)} : 7'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? {5'd0, 2'($urandom)} : 7'($urandom);
            iv = ($urandom_range(0, 9) < 6);
            ii = mk(8'h01 << $urandom_range(0, 7), {$urandom, $urandom}, {$urandom, $urandom},
                    7'($urandom), r1, r2);
            er = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 24) == 0);
            wb[$urandom_range(0, 127)] = 1'b1;
            wb[$urandom_range(0, 127)] = 1'b1;
            wb[$urandom_range(0, 127)] = 1'b1;
            if (c % 60 == 59) wb = '0;
            rst_n = ($urandom_range(0, 149) != 0);
            if (!rst_n) begin
                #1;
                model_reset();
            end
            cycle();
            rst_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
